// File: rtl/mux_nx1_stream.sv
// N-to-1 valid/ready stream multiplexer with manual or round-robin channel selection.
// Optional MUX_NX1_PARITY_EN adds a registered even-parity output bit.
module mux_nx1_stream #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
`ifdef MUX_NX1_PARITY_EN
    output logic                 out_parity,
`endif
    input  logic                 out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load;
    logic             xfer_in;

    always_comb begin
        int c;
        c = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            // Scan upward from the channel after the last one served.
            for (int k = 1; k <= NCH; k++) begin
                c = (int'(ptr_q) + k) % NCH;
                if (!gnt_any && in_valid[c]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(c);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == gnt_idx) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load     = ~out_valid_q | out_ready;
    assign xfer_in  = gnt_any & load & ~rst;
    assign in_ready = xfer_in ? (NCH'(1) << gnt_idx) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q & ~out_ready;
        ptr_d       = ptr_q;
        if (xfer_in) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef MUX_NX1_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (xfer_in) begin
            par_d = ^gnt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_parity = par_q;
`endif

endmodule

// File: doc/mux_nx1_stream.md
MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal values 1..64).
REQ-002 SHALL have parameter NCH, default 4, meaning number of input channels (legal values 2..16).
REQ-003 SHALL have localparam SELW = $clog2(NCH), meaning channel-index width.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  NCH  per-channel valid.
REQ-008 SHALL have port in_ready  output  NCH  per-channel accept, combinational.
REQ-009 SHALL have port mode  input  1  0 = manual select, 1 = round-robin scan.
REQ-010 SHALL have port sel  input  SELW  manual channel index.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_ch  output  SELW  registered index of the source channel.
REQ-013 SHALL have port out_valid  output  1  output holds a word.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL define a transfer on either side as valid & ready high at the rising edge of clk.
REQ-016 SHALL define load = ~out_valid | out_ready; the output register accepts a new word only when load is high.
REQ-017 SHALL, in manual mode, grant channel sel when in_valid[sel] is high; sel >= NCH SHALL grant nothing.
REQ-018 SHALL, in round-robin mode, grant the first channel with in_valid high, searching upward from (ptr+1) mod NCH and wrapping.
REQ-019 SHALL update ptr to the granted index only on an input transfer; ptr SHALL hold otherwise, including in manual mode.
REQ-020 SHALL drive in_ready[i] = grant[i] & load, with at most one bit high.
REQ-021 SHALL, on an input transfer, register out_data, out_ch and set out_valid at that edge (latency 1 cycle).
REQ-022 SHALL clear out_valid after an output transfer with no simultaneous input transfer.
REQ-023 SHALL, on simultaneous output and input transfers, replace the word without a bubble (full throughput, 1 word/cycle).
REQ-024 SHALL hold out_data, out_ch and out_valid stable while out_valid & ~out_ready.
REQ-025 SHALL sample mode and sel combinationally each cycle; a change SHALL affect only the next grant, never a held output word.
REQ-026 SHALL drive all in_ready bits low when no channel is valid, or when no channel is granted.

Reset
REQ-027 SHALL, while rst is high, force out_valid=0, out_data=0, out_ch=0 and ptr=NCH-1, so the first scan starts at channel 0.
REQ-028 SHALL drop a held, unaccepted word if rst asserts mid-operation; no word SHALL be emitted after rst deasserts until a new input transfer.
REQ-029 SHALL drive all in_ready bits low while rst is high.

Configuration
REQ-030 SHALL, when MUX_NX1_PARITY_EN is defined, add port out_parity  output  1, the registered even parity (XOR reduction) of the word loaded into out_data, updated with out_data and reset to 0.
REQ-031 SHALL, when MUX_NX1_PARITY_EN is undefined, have no out_parity port and no parity logic; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover manual mode: NCH=4, WIDTH=8, mode=0, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
REQ-033 SHALL cover round-robin: mode=1, in_valid=4'b1111 held, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-034 SHALL cover skip and wrap: mode=1, ptr=2, in_valid=4'b0010 -> grant channel 1 (wrap past 3 and 0); out_ch=1.
REQ-035 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0000 and out_data unchanged; out_ready=1 -> next word loads the same cycle.
REQ-036 SHALL cover out-of-range select and reset: NCH=3, sel=3 -> in_ready=000, out_valid stays 0; rst pulse while out_valid=1 -> out_valid=0 immediately, out_ch=0.
REQ-037 SHALL cover parity, with MUX_NX1_PARITY_EN defined: a loaded word 8'h07 -> out_parity=1; a loaded word 8'h03 -> out_parity=0.
